// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store sequencer.
package dmem_pkg;

    // Load/store width and signedness encoding carried on req_ctrl.
    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dmctrl_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int DM_MAX_BYTES = 4;

    // Number of SRAM byte accesses for an encoding; illegal encodings report 1
    // so the range check stays well defined (they are rejected anyway).
    function automatic logic [2:0] dm_nbytes(input logic [2:0] ctrl);
        case (ctrl)
            DM_H, DM_HU: dm_nbytes = 3'd2;
            DM_W:        dm_nbytes = 3'd4;
            default:     dm_nbytes = 3'd1;
        endcase
    endfunction

    // Encodings with no defined load/store meaning.
    function automatic logic dm_illegal(input logic [2:0] ctrl);
        dm_illegal = (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  ctrl,
    output logic [31:0] ext
);

    // Select extension from the low byte/half according to the encoding.
    always_comb begin
        ext = raw;
        case (ctrl)
            DM_B:    ext = {{24{raw[7]}}, raw[7:0]};
            DM_H:    ext = {{16{raw[15]}}, raw[15:0]};
            DM_BU:   ext = {24'd0, raw[7:0]};
            DM_HU:   ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_access_sequencer.sv
// Load/store sequencer: one request per handshake, one SRAM byte per cycle,
// one response pulse per request. Bad requests never touch the SRAM.
module dmem_access_sequencer
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_ctrl,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    state_e state, state_nx;

    // Latched request
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        ctrl_q;
    logic              err_q;

    // Byte sequencing and load capture
    logic [1:0]  k_q;
    logic        rd_pend_q;
    logic [1:0]  rd_lane_q;
    logic [31:0] ld_data_q;
    logic [31:0] ld_ext;
    logic [2:0]  nbytes_q;
    logic        last_byte;
    logic [7:0]  wbyte;

    // Accept-time request checks
    logic        accept;
    logic [2:0]  in_nbytes;
    logic [32:0] in_last;
    logic        in_misalign;
    logic        req_err;

    assign accept    = req_valid & req_ready;
    assign in_nbytes = dm_nbytes(req_ctrl);
    // 33-bit sum so an address that wraps past 2^32 still counts as out of range
    assign in_last   = {1'b0, req_addr} + {30'd0, in_nbytes} - 33'd1;

    assign in_misalign = MISALIGN_ERR &&
                         ((((req_ctrl == DM_H) || (req_ctrl == DM_HU)) && req_addr[0]) ||
                          ((req_ctrl == DM_W) && (req_addr[1:0] != 2'b00)));

    assign req_err   = dm_illegal(req_ctrl) || in_misalign || (in_last >= DEPTH);

    assign nbytes_q  = dm_nbytes(ctrl_q);
    assign last_byte = ({1'b0, k_q} == (nbytes_q - 3'd1));

    dmem_load_extend u_ext (
        .raw  (ld_data_q),
        .ctrl (ctrl_q),
        .ext  (ld_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = req_err ? RESP : ACCESS;
            ACCESS:  if (last_byte) state_nx = we_q ? RESP : DRAIN;
            DRAIN:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, byte counter and load-byte capture (read data lags issue by one cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ctrl_q    <= '0;
            err_q     <= 1'b0;
            k_q       <= '0;
            rd_pend_q <= 1'b0;
            rd_lane_q <= '0;
            ld_data_q <= '0;
        end else begin
            if (accept) begin
                we_q      <= req_we;
                addr_q    <= req_addr[ADDR_W-1:0];
                wdata_q   <= req_wdata;
                ctrl_q    <= req_ctrl;
                err_q     <= req_err;
                k_q       <= '0;
                ld_data_q <= '0;
            end else if (state == ACCESS) begin
                k_q <= k_q + 2'd1;
            end
            rd_pend_q <= (state == ACCESS) && !we_q;
            rd_lane_q <= k_q;
            if (rd_pend_q) ld_data_q[{rd_lane_q, 3'b000} +: 8] <= mem_rdata;
        end
    end

    // Store byte for the current lane
    always_comb begin
        wbyte = wdata_q[7:0];
        case (k_q)
            2'd0: wbyte = wdata_q[7:0];
            2'd1: wbyte = wdata_q[15:8];
            2'd2: wbyte = wdata_q[23:16];
            2'd3: wbyte = wdata_q[31:24];
            default: wbyte = wdata_q[7:0];
        endcase
    end

    // Outputs; everything held at 0 while rst is high
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!rst) begin
            case (state)
                IDLE: req_ready = 1'b1;
                ACCESS: begin
                    mem_en    = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = addr_q + ADDR_W'(k_q);
                    mem_wdata = wbyte;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    resp_err   = err_q;
                    resp_rdata = (err_q || we_q) ? 32'd0 : ld_ext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Directed bench: two sequencers (misalign-error on / off) share one request
// stream, each backed by its own byte SRAM model.
module tb_dmem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_ctrl;

    logic        rdy_a, rv_a, re_a, men_a, mwe_a;
    logic [31:0] rd_a;
    logic [11:0] maddr_a;
    logic [7:0]  mwd_a, mrd_a;
    logic        rdy_b, rv_b, re_b, men_b, mwe_b;
    logic [31:0] rd_b;
    logic [11:0] maddr_b;
    logic [7:0]  mwd_b, mrd_b;

    logic [7:0]  ram_a [0:4095];
    logic [7:0]  ram_b [0:4095];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_access_sequencer #(.ADDR_W(12), .MISALIGN_ERR(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .resp_valid(rv_a), .resp_err(re_a), .resp_rdata(rd_a),
        .mem_en(men_a), .mem_we(mwe_a), .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_rdata(mrd_a)
    );

    dmem_access_sequencer #(.ADDR_W(12), .MISALIGN_ERR(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .resp_valid(rv_b), .resp_err(re_b), .resp_rdata(rd_b),
        .mem_en(men_b), .mem_we(mwe_b), .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_rdata(mrd_b)
    );

    // SRAM model A: registered read, one byte per enable
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) ram_a[i] <= 8'h00;
            mrd_a <= 8'h00;
        end else if (men_a) begin
            if (mwe_a) ram_a[maddr_a] <= mwd_a;
            else       mrd_a <= ram_a[maddr_a];
        end
    end

    // SRAM model B
    always @(posedge clk) begin
        if (clr) begin
            for (int j = 0; j < 4096; j++) ram_b[j] <= 8'h00;
            mrd_b <= 8'h00;
        end else if (men_b) begin
            if (mwe_b) ram_b[maddr_b] <= mwd_b;
            else       mrd_b <= ram_b[maddr_b];
        end
    end

    // Issue one request to both DUTs and record response cycle (relative to the
    // accept edge), error, data and SRAM enable count; -1 latency = no response.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] ctrl,
                           output int lat_a, output logic err_a, output logic [31:0] dat_a, output int nen_a,
                           output int lat_b, output logic err_b, output logic [31:0] dat_b, output int nen_b);
        lat_a = -1; err_a = 1'b0; dat_a = '0; nen_a = 0;
        lat_b = -1; err_b = 1'b0; dat_b = '0; nen_b = 0;
        req_we = we; req_addr = addr; req_wdata = wd; req_ctrl = ctrl; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (men_a) nen_a++;
            if (men_b) nen_b++;
            if (rv_a && lat_a < 0) begin lat_a = c; err_a = re_a; dat_a = rd_a; end
            if (rv_b && lat_b < 0) begin lat_b = c; err_b = re_b; dat_b = rd_b; end
            if (lat_a >= 0 && lat_b >= 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; req_ctrl = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", rdy_a); end
        total++; if ({rv_a, re_a, rd_a} !== 34'd0) begin bad++; $display("FAIL rst_resp got=%b/%b/%h exp=0/0/0", rv_a, re_a, rd_a); end
        total++; if ({men_a, mwe_a, maddr_a, mwd_a} !== 22'd0) begin bad++; $display("FAIL rst_mem got=%b/%b/%h/%h exp=all 0", men_a, mwe_a, maddr_a, mwd_a); end
        req_valid = 1'b0; rst = 1'b0; clr = 1'b0;
        #1;
        total++; if ({rdy_a, rdy_b} !== 2'b11) begin bad++; $display("FAIL rst_release_ready got=%b exp=11", {rdy_a, rdy_b}); end
        @(posedge clk); #1;
        total++; if ({rdy_a, men_a, rv_a} !== 3'b100) begin bad++; $display("FAIL idle_after_rst got=%b exp=100", {rdy_a, men_a, rv_a}); end
    endtask

    task automatic test_store_load();
        int la, lb, na, nb; logic ea, eb; logic [31:0] da, db;
        run_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 5 || ea !== 1'b0 || da !== 32'd0) begin bad++; $display("FAIL sw_resp got lat=%0d err=%b data=%h exp lat=5 err=0 data=0", la, ea, da); end
        total++; if (na !== 4) begin bad++; $display("FAIL sw_mem_en got=%0d exp=4", na); end
        total++; if ({ram_a[16'h10], ram_a[16'h11], ram_a[16'h12], ram_a[16'h13]} !== 32'hEFBE_ADDE) begin
            bad++; $display("FAIL sw_sram got=%h %h %h %h exp=EF BE AD DE", ram_a[16'h10], ram_a[16'h11], ram_a[16'h12], ram_a[16'h13]); end
        run_req(1'b0, 32'h10, 32'h0, 3'b010, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 6 || ea !== 1'b0 || da !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_resp got lat=%0d err=%b data=%h exp lat=6 err=0 data=deadbeef", la, ea, da); end
        total++; if (na !== 4) begin bad++; $display("FAIL lw_mem_en got=%0d exp=4", na); end
        run_req(1'b1, 32'h14, 32'h4433_2211, 3'b010, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 5 || ea !== 1'b0) begin bad++; $display("FAIL sw14_resp got lat=%0d err=%b exp lat=5 err=0", la, ea); end
    endtask

    task automatic test_extend();
        int la, lb, na, nb; logic ea, eb; logic [31:0] da, db;
        run_req(1'b1, 32'h20, 32'h0000_0080, 3'b000, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 2 || ea !== 1'b0 || na !== 1) begin bad++; $display("FAIL sb_resp got lat=%0d err=%b en=%0d exp lat=2 err=0 en=1", la, ea, na); end
        run_req(1'b0, 32'h20, 32'h0, 3'b000, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 3 || da !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_sext got lat=%0d data=%h exp lat=3 data=ffffff80", la, da); end
        run_req(1'b0, 32'h20, 32'h0, 3'b100, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 3 || da !== 32'h0000_0080) begin bad++; $display("FAIL lbu_zext got lat=%0d data=%h exp lat=3 data=00000080", la, da); end
        run_req(1'b1, 32'h22, 32'h0000_8001, 3'b001, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 3 || {ram_a[16'h22], ram_a[16'h23]} !== 16'h0180) begin
            bad++; $display("FAIL sh_store got lat=%0d bytes=%h %h exp lat=3 bytes=01 80", la, ram_a[16'h22], ram_a[16'h23]); end
        run_req(1'b0, 32'h22, 32'h0, 3'b001, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 4 || da !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_sext got lat=%0d data=%h exp lat=4 data=ffff8001", la, da); end
        run_req(1'b0, 32'h22, 32'h0, 3'b101, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 4 || da !== 32'h0000_8001) begin bad++; $display("FAIL lhu_zext got lat=%0d data=%h exp lat=4 data=00008001", la, da); end
    endtask

    task automatic test_misalign();
        int la, lb, na, nb; logic ea, eb; logic [31:0] da, db;
        run_req(1'b0, 32'h13, 32'h0, 3'b010, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 1 || ea !== 1'b1 || da !== 32'd0 || na !== 0) begin
            bad++; $display("FAIL misalign_err got lat=%0d err=%b data=%h en=%0d exp lat=1 err=1 data=0 en=0", la, ea, da, na); end
        total++; if (lb !== 6 || eb !== 1'b0 || db !== 32'h3322_11DE || nb !== 4) begin
            bad++; $display("FAIL misalign_ok got lat=%0d err=%b data=%h en=%0d exp lat=6 err=0 data=332211de en=4", lb, eb, db, nb); end
    endtask

    task automatic test_errors();
        int la, lb, na, nb; logic ea, eb; logic [31:0] da, db;
        run_req(1'b0, 32'h0000_0FFF, 32'h0, 3'b001, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 1 || lb !== 1 || {ea, eb} !== 2'b11 || na + nb !== 0) begin
            bad++; $display("FAIL lh_range got lat=%0d/%0d err=%b%b en=%0d exp lat=1/1 err=11 en=0", la, lb, ea, eb, na + nb); end
        run_req(1'b0, 32'hFFFF_FFFC, 32'h0, 3'b010, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 1 || lb !== 1 || {ea, eb} !== 2'b11 || na + nb !== 0) begin
            bad++; $display("FAIL lw_wrap got lat=%0d/%0d err=%b%b en=%0d exp lat=1/1 err=11 en=0", la, lb, ea, eb, na + nb); end
        run_req(1'b1, 32'h0000_0000, 32'h1234_5678, 3'b011, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 1 || lb !== 1 || {ea, eb} !== 2'b11 || {da, db} !== 64'd0 || na + nb !== 0) begin
            bad++; $display("FAIL ctrl_illegal got lat=%0d/%0d err=%b%b data=%h/%h en=%0d exp lat=1/1 err=11 data=0 en=0", la, lb, ea, eb, da, db, na + nb); end
        run_req(1'b0, 32'h0000_0FFF, 32'h0, 3'b000, la, ea, da, na, lb, eb, db, nb);
        total++; if (la !== 3 || ea !== 1'b0 || da !== 32'd0 || na !== 1) begin
            bad++; $display("FAIL lb_top_byte got lat=%0d err=%b data=%h en=%0d exp lat=3 err=0 data=0 en=1", la, ea, da, na); end
    endtask

    task automatic test_reset_mid();
        int nresp;
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h1122_3344; req_ctrl = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if ({men_a, mwe_a, maddr_a, mwd_a} !== {2'b11, 12'h030, 8'h44}) begin
            bad++; $display("FAIL mid_first_byte got en=%b we=%b addr=%h data=%h exp 1 1 030 44", men_a, mwe_a, maddr_a, mwd_a); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if ({men_a, rdy_a, rv_a} !== 3'b000) begin bad++; $display("FAIL mid_rst_outputs got=%b exp=000", {men_a, rdy_a, rv_a}); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b exp=1", rdy_a); end
        nresp = 0;
        for (int c = 0; c < 6; c++) begin
            if (rv_a || rv_b) nresp++;
            @(posedge clk); #1;
        end
        total++; if (nresp !== 0) begin bad++; $display("FAIL mid_no_resp got=%0d exp=0", nresp); end
        total++; if ({ram_a[16'h30], ram_a[16'h32], ram_a[16'h33]} !== 24'h44_00_00) begin
            bad++; $display("FAIL mid_sram got=%h %h %h exp=44 00 00", ram_a[16'h30], ram_a[16'h32], ram_a[16'h33]); end
    endtask

    task automatic test_back_to_back();
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0000_005A; req_ctrl = 3'b000; req_valid = 1'b1;
        #1;
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL b2b_c0_ready got=%b exp=1", rdy_a); end
        @(posedge clk); #1;
        // Second request (lb) presented while the store is still in flight
        req_we = 1'b0; req_wdata = 32'h0000_00FF;
        total++; if ({rdy_a, rv_a} !== 2'b00) begin bad++; $display("FAIL b2b_c1 got ready/valid=%b exp=00", {rdy_a, rv_a}); end
        @(posedge clk); #1;
        total++; if ({rdy_a, rv_a, re_a} !== 3'b010) begin bad++; $display("FAIL b2b_c2 got ready/valid/err=%b exp=010", {rdy_a, rv_a, re_a}); end
        @(posedge clk); #1;
        total++; if ({rdy_a, rv_a} !== 2'b10) begin bad++; $display("FAIL b2b_c3 got ready/valid=%b exp=10", {rdy_a, rv_a}); end
        @(posedge clk); #1;
        total++; if ({rdy_a, rv_a, men_a} !== 3'b001) begin bad++; $display("FAIL b2b_c4 got ready/valid/en=%b exp=001", {rdy_a, rv_a, men_a}); end
        @(posedge clk); #1;
        total++; if ({rdy_a, rv_a, men_a} !== 3'b000) begin bad++; $display("FAIL b2b_c5 got ready/valid/en=%b exp=000", {rdy_a, rv_a, men_a}); end
        @(posedge clk); #1;
        total++; if ({rdy_a, rv_a, re_a} !== 3'b010 || rd_a !== 32'h0000_005A) begin
            bad++; $display("FAIL b2b_c6 got ready/valid/err=%b data=%h exp=010 data=0000005a", {rdy_a, rv_a, re_a}, rd_a); end
        req_valid = 1'b0;
        @(posedge clk); #1;
        total++; if ({rdy_a, rv_a} !== 2'b10 || ram_a[16'h40] !== 8'h5A) begin
            bad++; $display("FAIL b2b_end got ready/valid=%b sram=%h exp=10 sram=5a", {rdy_a, rv_a}, ram_a[16'h40]); end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_ctrl = '0;
        test_reset();
        test_store_load();
        test_extend();
        test_misalign();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
